// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register-bank write-port arbiter:
//   - FSM state encoding (ST_IDLE / ST_OWN)
//   - default parameter values
//   - round-robin pick function: given a request vector and a start pointer,
//     returns the first requesting index at or after the pointer (with
//     wrap-around) and a valid flag.
// -----------------------------------------------------------------------------
package reg_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 8;
    localparam int AW_DEF        = 3;
    localparam int MAX_BURST_DEF = 4;

    // The pick function works on a fixed-width request vector so it can be
    // shared by any instance with NREQ <= MAX_NREQ; unused upper bits are zero.
    localparam int MAX_NREQ = 32;
    localparam int IDX_W    = 5;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                      input logic [IDX_W-1:0]    ptr,
                                      input int                  nreq);
        pick_t r;
        int    j;
        r = '0;
        // Walk the offsets from the far end back toward the pointer so the
        // last assignment made is the closest requester to ptr.
        for (int k = MAX_NREQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                j = int'(ptr) + k;
                if (j >= nreq) begin
                    j = j - nreq;
                end
                if (req[j[IDX_W-1:0]]) begin
                    r.valid = 1'b1;
                    r.idx   = j[IDX_W-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
// 2**AW x DW register storage with a single synchronous write port and an
// asynchronous (combinational) read port. All entries clear on reset.
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  bank[raddr], combinational
// -----------------------------------------------------------------------------
module reg_bank #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// reg_bank_arbiter
// Round-robin arbiter sharing the single write port of a register bank among
// NREQ requesters, with lock-extended bursts capped at MAX_BURST cycles.
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   req      in   NREQ      per-requester write request
//   lock     in   NREQ      per-requester burst hold (only with req)
//   wr_addr  in   NREQ*AW   packed write addresses, slice i = requester i
//   wr_data  in   NREQ*DW   packed write data, slice i = requester i
//   gnt      out  NREQ      registered grant, one-hot or zero
//   busy     out  1         high while a grant is held
//   rd_addr  in   AW        read address
//   rd_data  out  DW        bank[rd_addr], combinational
// -----------------------------------------------------------------------------
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int AW        = AW_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] wr_addr,
    input  logic [NREQ*DW-1:0] wr_data,
    output logic [NREQ-1:0]    gnt,
    output logic               busy,
    input  logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      rd_data
);

    localparam int               BCW     = $clog2(MAX_BURST + 1);
    localparam logic [BCW-1:0]   MAX_CNT = BCW'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST    = IDX_W'(NREQ - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_owner_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [IDX_W-1:0]      w_ptr_rel;
    logic [BCW-1:0]        r_cnt;
    logic [BCW-1:0]        w_cnt_nxt;
    logic [NREQ-1:0]       r_gnt;
    logic [NREQ-1:0]       w_gnt_nxt;
    logic [MAX_NREQ-1:0]   w_req_ext;
    logic                  w_own_req;
    logic                  w_own_lock;
    pick_t                 w_pick_idle;
    pick_t                 w_pick_rel;
    logic                  w_we;
    logic [AW-1:0]         w_waddr;
    logic [DW-1:0]         w_wdata;

    assign w_req_ext  = MAX_NREQ'(req);
    // r_gnt is one-hot on the owner while in OWN, so masking gives the
    // owner's own req/lock bits without a variable index.
    assign w_own_req  = |(req & r_gnt);
    assign w_own_lock = |(lock & r_gnt);

    // Pointer that takes effect on release: one past the current owner.
    assign w_ptr_rel   = (r_owner == LAST) ? '0 : r_owner + 1'b1;
    assign w_pick_idle = rr_pick(w_req_ext, r_ptr, NREQ);
    // Re-arbitration in the release edge uses the already-advanced pointer.
    assign w_pick_rel  = rr_pick(w_req_ext, w_ptr_rel, NREQ);

    // Next-state / next-grant logic.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = '0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle.valid) begin
                    w_state_nxt = ST_OWN;
                    w_owner_nxt = w_pick_idle.idx;
                    w_cnt_nxt   = BCW'(1);
                end
            end
            ST_OWN: begin
                if (w_own_req && w_own_lock && (r_cnt < MAX_CNT)) begin
                    w_cnt_nxt = r_cnt + BCW'(1);
                end else begin
                    w_ptr_nxt = w_ptr_rel;
                    if (w_pick_rel.valid) begin
                        w_owner_nxt = w_pick_rel.idx;
                        w_cnt_nxt   = BCW'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt == ST_OWN) begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_owner_nxt == IDX_W'(i)) begin
                    w_gnt_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    // Write-port mux: only the current owner's slice reaches the bank, and
    // only when the owner is still requesting this cycle.
    always_comb begin
        w_we    = (r_state == ST_OWN) && w_own_req;
        w_waddr = '0;
        w_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gnt[i]) begin
                w_waddr = wr_addr[i*AW +: AW];
                w_wdata = wr_data[i*DW +: DW];
            end
        end
    end

    reg_bank #(
        .DW (DW),
        .AW (AW)
    ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign gnt  = r_gnt;
    assign busy = (r_state == ST_OWN);

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_arbiter
// Directed bench for reg_bank_arbiter (NREQ=4, DW=8, AW=3, MAX_BURST=4).
// Expected grants are queued as each step is driven and popped after the edge;
// a shadow bank tracks which writes the owner should have made.
// -----------------------------------------------------------------------------
module tb_reg_bank_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  gnt;
    logic        busy;
    logic [2:0]  rd_addr;
    logic [7:0]  rd_data;

    int          checks;
    int          errors;
    logic [3:0]  q_gnt[$];
    logic [3:0]  exp_cur;
    logic [7:0]  model [8];
    logic [2:0]  a_addr [4];
    logic [7:0]  a_data [4];

    reg_bank_arbiter #(
        .NREQ      (4),
        .DW        (8),
        .AW        (3),
        .MAX_BURST (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .lock    (lock),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .gnt     (gnt),
        .busy    (busy),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus (called just after a falling edge), check
    // grant/busy/read after the rising edge, and return at the next falling edge.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] eg);
        req  = r;
        lock = l;
        for (int i = 0; i < 4; i++) begin
            wr_addr[i*3 +: 3] = a_addr[i];
            wr_data[i*8 +: 8] = a_data[i];
        end
        q_gnt.push_back(eg);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (exp_cur[i] && r[i]) begin
                model[a_addr[i]] = a_data[i];
            end
        end
        exp_cur = q_gnt.pop_front();
        chk({tag, "_gnt"}, 32'(gnt), 32'(exp_cur));
        chk({tag, "_busy"}, 32'(busy), 32'(|exp_cur));
        chk({tag, "_rd"}, 32'(rd_data), 32'(model[rd_addr]));
        @(negedge clk);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 8; a++) begin
            rd_addr = 3'(a);
            #1;
            chk(tag, 32'(rd_data), 32'(model[a]));
        end
    endtask

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        req     = '0;
        lock    = '0;
        wr_addr = '0;
        wr_data = '0;
        rd_addr = '0;
        exp_cur = '0;
        checks  = 0;
        errors  = 0;
        for (int a = 0; a < 8; a++) model[a] = '0;
        for (int i = 0; i < 4; i++) begin
            a_addr[i] = '0;
            a_data[i] = '0;
        end

        // Power-on reset state.
        repeat (2) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        sweep("rst_bank");
        @(negedge clk);
        rst = 1'b0;

        // Fair rotation with all requesters active, new addr/data every cycle.
        for (int s = 1; s <= 8; s++) begin
            for (int i = 0; i < 4; i++) begin
                a_addr[i] = 3'(i + s);
                a_data[i] = 8'(16 * s + i);
            end
            rd_addr = 3'(s);
            step("rot", 4'b1111, 4'b0000, 4'(1 << ((s - 1) % 4)));
        end
        step("rot_idle", 4'b0000, 4'b0000, 4'b0000);
        sweep("rot_bank");
        @(negedge clk);

        // Locked burst capped at four cycles, then requester 0, then back.
        step("burst0", 4'b0100, 4'b0100, 4'b0100);
        repeat (3) step("burst_hold", 4'b0101, 4'b0100, 4'b0100);
        step("burst_rel", 4'b0101, 4'b0100, 4'b0001);
        step("burst_back", 4'b0101, 4'b0100, 4'b0100);

        // Lone requester re-granted without a bubble, then back to idle.
        repeat (3) step("lone", 4'b0100, 4'b0000, 4'b0100);
        step("to_idle", 4'b0000, 4'b0000, 4'b0000);
        step("idle_stay", 4'b0000, 4'b0000, 4'b0000);

        // Requester 1 writes A5 to addr 5, then drops req while granted.
        a_addr[1] = 3'd5;
        a_data[1] = 8'hA5;
        rd_addr   = 3'd5;
        step("drop_g", 4'b0010, 4'b0000, 4'b0010);
        step("drop_w", 4'b0010, 4'b0000, 4'b0010);
        chk("drop_a5", 32'(rd_data), 32'hA5);
        a_data[1] = 8'h5A;
        step("drop_rel", 4'b0000, 4'b0000, 4'b0000);
        chk("drop_keep", 32'(rd_data), 32'hA5);

        // Read-during-write on addr 3.
        a_addr[3] = 3'd3;
        a_data[3] = 8'h3C;
        rd_addr   = 3'd3;
        step("rdw_g", 4'b1000, 4'b0000, 4'b1000);
        chk("rdw_old", 32'(rd_data), 32'(model[3]));
        step("rdw_w", 4'b1000, 4'b0000, 4'b1000);
        chk("rdw_new", 32'(rd_data), 32'h3C);

        // Reset asserted in the middle of a locked burst.
        a_data[3] = 8'h77;
        step("rb_hold", 4'b1000, 4'b1000, 4'b1000);
        step("rb_hold", 4'b1000, 4'b1000, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(gnt), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        for (int a = 0; a < 8; a++) model[a] = '0;
        exp_cur = '0;
        sweep("mid_rst_bank");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst", 4'b1111, 4'b0000, 4'b0001);
        step("post_rst2", 4'b1111, 4'b0000, 4'b0010);
        step("end_idle", 4'b0000, 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Round-robin arbiter that shares the single write port of a small register bank among NREQ requesters, with optional locked bursts and a starvation bound. It owns the bank storage, an 8-entry array of D flip-flop registers, and exposes one asynchronous read port. It sits between producer blocks and the shared configuration/status registers they update.

## Interface
- NREQ, 4: number of requesters.
- DW, 8: register width.
- AW, 3: address width; bank depth is 2**AW.
- MAX_BURST, 4: maximum consecutive granted cycles per ownership, ≥1.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester write request.
- lock  in  NREQ  per-requester burst hold; ignored unless the matching req is also high.
- wr_addr  in  NREQ*AW  packed write addresses; slice i belongs to requester i.
- wr_data  in  NREQ*DW  packed write data; slice i belongs to requester i.
- gnt  out  NREQ  registered grant; one-hot or zero.
- busy  out  1  high while any grant is held.
- rd_addr  in  AW  read address.
- rd_data  out  DW  combinational read, bank[rd_addr].

## Operation
- Two-state FSM:
  - IDLE: gnt=0, busy=0.
  - OWN: gnt one-hot on owner o, busy=1.
- Round-robin pointer ptr, 0..NREQ-1:
  - The winner is the first i with req[i]=1, searching ptr, ptr+1, … with wrap-around modulo NREQ.
  - On every release, ptr becomes o+1 (mod NREQ).
- IDLE → OWN: at a rising edge where req≠0. gnt[winner]=1, burst_cnt=1.
- Granted cycle, gnt[o]=1:
  - If req[o]=1, bank[wr_addr slice o] ← wr_data slice o at the ending edge.
  - Other requesters' slices are never written.
- At the edge ending an OWN cycle:
  - Hold: if req[o] and lock[o] and burst_cnt<MAX_BURST, keep o and increment burst_cnt.
  - Release otherwise, covering !req[o], !lock[o], or burst_cnt==MAX_BURST. Set ptr=o+1 and re-arbitrate in the same edge with the updated ptr.
  - If a winner exists, move to OWN with the new owner and burst_cnt=1. There is no bubble between owners.
  - If no winner, move to IDLE.
  - After a release, the same requester may win again only if it is the first requester found from ptr. With a lone requester it is re-granted back-to-back.
- A granted requester that drops req performs no write that cycle. Its grant is released at that edge.
- Reset, asynchronous: state=IDLE, gnt=0, busy=0, ptr=0, burst_cnt=0, all bank entries=0, so rd_data=0.
- A reset assertion mid-burst aborts immediately. The write of the current cycle is lost.

## Timing
- Request-to-grant latency: 1 cycle from IDLE.
  - req sampled at edge k → gnt visible after edge k → data written at edge k+1.
- Throughput: 1 write per cycle while any requester is active.
- Read-during-write: rd_data shows the old value until the writing edge, and the new value after it.
- Maximum wait for any requester with req held: (NREQ-1)*MAX_BURST granted cycles.
- burst_cnt is ceil(log2(MAX_BURST+1)) bits and saturates logically at MAX_BURST. It never wraps.

## Structure
- Shared package reg_arb_pkg contains:
  - state encoding constants: ST_IDLE=0, ST_OWN=1.
  - default parameter values.
  - the round-robin pick function (req, ptr) → index/valid.
- Sub-module reg_bank contains the 2**AW × DW storage with one write port (we, waddr, wdata), the async read port, and the async reset to zero.
- reg_bank_arbiter contains the FSM, ptr, burst_cnt, and the write-port mux that selects the owner's slice.

## Test plan
- Reset: rst=1 mid-simulation while a burst is active. gnt=0, busy=0, every rd_addr reads 0. After release, req=4'b1111 is granted to requester 0 first.
- Fair rotation: req=4'b1111, lock=0 held for 8 cycles. gnt sequence is 0001, 0010, 0100, 1000, 0001, … and each cycle writes that requester's slice.
- Burst bound: MAX_BURST=4, req[2]=lock[2]=1, req[0]=1. Requester 2 holds 4 consecutive cycles, then gnt=0001, then 0100 again.
- Drop and write check: requester 1 is granted with addr=5, data=8'hA5, then req[1] drops while granted. The next grant contains no write and the grant is released. rd_addr=5 shows A5 only after the first writing edge.
- Lone requester and idle: req=4'b0100 alone is re-granted every cycle with no bubble. When req=0, the FSM returns to IDLE one edge later with busy=0.
- Read-during-write: write addr 3 = 8'h3C while rd_addr=3. rd_data shows the old value before the edge and 3C after it.
